// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF stage. Holds the PC, addresses instruction memory,
// latches the fetched word and PC-derived values into IF/ID, honours
// hazard stalls and halts fetch when the next PC leaves instruction memory.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      npc,
  output logic [31:0]      pc4,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_pc8,
  output logic             id_valid,
  output logic             fetch_err,
  output logic [31:0]      err_addr,
  output logic [31:0]      fetch_cnt
);

  // Legal fetch window, widened to 33 bits so the top bound never wraps.
  localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI = PC_LO + (33'd1 << (IM_AW + 2)) - 33'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] id_instr_q,  id_instr_d;
  logic [31:0] id_pc_q,     id_pc_d;
  logic [31:0] id_pc4_q,    id_pc4_d;
  logic [31:0] id_pc8_q,    id_pc8_d;
  logic        id_valid_q,  id_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] err_addr_q,  err_addr_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] pc_off;
  logic [31:0] nxt_pc;
  logic [32:0] nxt_wide;
  logic        nxt_aligned;
  logic        nxt_in_range;
  logic        nxt_legal;
  logic        unused_pc_off_bits;

  // PC arithmetic and the instruction-memory word index.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_plus8 = pc_q + 32'd8;
    pc_off   = pc_q - RESET_PC;
  end

  assign im_addr            = pc_off[IM_AW+1:2];
  assign unused_pc_off_bits = ^{pc_off[31:IM_AW+2], pc_off[1:0]};

  // Candidate next PC and its legality against the memory window.
  always_comb begin
    nxt_pc       = redirect ? npc : pc_plus4;
    nxt_wide     = {1'b0, nxt_pc};
    nxt_aligned  = (nxt_pc[1:0] == 2'b00);
    nxt_in_range = (nxt_wide >= PC_LO) && (nxt_wide <= PC_HI);
    nxt_legal    = nxt_aligned && nxt_in_range;
  end

  // Next-state and datapath update: fetch in RUN, bubble IF/ID in HALT.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_pc8_d    = id_pc8_q;
    id_valid_d  = id_valid_q;
    fetch_err_d = fetch_err_q;
    err_addr_d  = err_addr_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          // The current word always issues: it is either a sequential
          // instruction or the delay slot of an accepted redirect.
          id_instr_d  = im_rdata;
          id_pc_d     = pc_q;
          id_pc4_d    = pc_plus4;
          id_pc8_d    = pc_plus8;
          id_valid_d  = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          if (nxt_legal) begin
            pc_d = nxt_pc;
          end else begin
            fetch_err_d = 1'b1;
            err_addr_d  = nxt_pc;
            state_d     = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (!stall) begin
          id_instr_d = 32'd0;
          id_pc_d    = 32'd0;
          id_pc4_d   = 32'd0;
          id_pc8_d   = 32'd0;
          id_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State register; reset wins over stall, redirect and HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      id_instr_q  <= 32'd0;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd0;
      id_pc8_q    <= 32'd0;
      id_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      err_addr_q  <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_pc8_q    <= id_pc8_d;
      id_valid_q  <= id_valid_d;
      fetch_err_q <= fetch_err_d;
      err_addr_q  <= err_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign pc4       = pc_plus4;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign id_pc8    = id_pc8_q;
  assign id_valid  = id_valid_q;
  assign fetch_err = fetch_err_q;
  assign err_addr  = err_addr_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus a randomized run
// checked against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          IM_AW    = 10;
  localparam int          DEPTH    = 1 << IM_AW;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             redirect;
  logic [31:0]      npc;
  logic [31:0]      pc4;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc;
  logic [31:0]      id_pc4;
  logic [31:0]      id_pc8;
  logic             id_valid;
  logic             fetch_err;
  logic [31:0]      err_addr;
  logic [31:0]      fetch_cnt;

  logic [31:0] imem [DEPTH];

  int compared = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_halt;
  logic [31:0] m_instr, m_idpc, m_idpc4, m_idpc8;
  bit          m_valid;
  bit          m_err;
  logic [31:0] m_erraddr;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  assign im_rdata = imem[im_addr];

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IM_AW(IM_AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .npc(npc),
    .pc4(pc4), .im_addr(im_addr), .im_rdata(im_rdata),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4), .id_pc8(id_pc8),
    .id_valid(id_valid), .fetch_err(fetch_err), .err_addr(err_addr),
    .fetch_cnt(fetch_cnt)
  );

  // One clock of stimulus; the model applies the fetch rules to the same inputs.
  task automatic tick(input bit r, input bit s, input bit rd, input logic [31:0] np);
    logic [31:0]     nxt;
    longint unsigned n;
    bit              legal;
    int              idx;
    reset = r; stall = s; redirect = rd; npc = np;
    nxt   = rd ? np : m_pc + 32'd4;
    n     = {32'd0, nxt};
    legal = (n % 4 == 0) && (n >= RESET_PC) && (n < longint'(RESET_PC) + 4 * DEPTH);
    if (r) begin
      m_pc = RESET_PC; m_halt = 0; m_instr = 0; m_idpc = 0; m_idpc4 = 0;
      m_idpc8 = 0; m_valid = 0; m_err = 0; m_erraddr = 0; m_cnt = 0;
    end else if (!m_halt) begin
      if (!s) begin
        idx     = int'((m_pc - RESET_PC) / 4);
        m_instr = imem[idx];
        m_idpc  = m_pc;
        m_idpc4 = m_pc + 4;
        m_idpc8 = m_pc + 8;
        m_valid = 1;
        m_cnt   = m_cnt + 1;
        if (legal) m_pc = nxt;
        else begin m_halt = 1; m_err = 1; m_erraddr = nxt; end
      end
    end else if (!s) begin
      m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_idpc8 = 0; m_valid = 0;
    end
    @(posedge clk);
    #1;
    $display("txn rst=%0b stall=%0b redir=%0b npc=%h | pc4=%h im_addr=%h id_pc=%h id_instr=%h v=%0b err=%0b cnt=%0d",
             r, s, rd, np, pc4, im_addr, id_pc, id_instr, id_valid, fetch_err, fetch_cnt);
  endtask

  task automatic test_reset();
    tick(1, 1, 1, 32'h1234_5678);
    tick(1, 0, 0, 0);
    compared++; if (pc4 !== 32'h3004) begin mismatched++; $display("FAIL reset_pc4 got %h exp %h", pc4, 32'h3004); end
    compared++; if (im_addr !== '0) begin mismatched++; $display("FAIL reset_im_addr got %h exp 0", im_addr); end
    compared++; if (id_valid !== 1'b0 || id_pc !== 0 || id_instr !== 0 || id_pc8 !== 0) begin
      mismatched++; $display("FAIL reset_ifid got v=%0b pc=%h instr=%h pc8=%h exp all 0", id_valid, id_pc, id_instr, id_pc8); end
    compared++; if (fetch_err !== 1'b0 || err_addr !== 0 || fetch_cnt !== 0) begin
      mismatched++; $display("FAIL reset_err_cnt got err=%0b addr=%h cnt=%0d exp 0", fetch_err, err_addr, fetch_cnt); end
  endtask

  task automatic test_free_run();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 3; i++) imem[i] = words[i];
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      compared++; if (id_pc !== RESET_PC + 4 * i) begin mismatched++; $display("FAIL free_run_id_pc got %h exp %h", id_pc, RESET_PC + 4 * i); end
      compared++; if (id_instr !== words[i]) begin mismatched++; $display("FAIL free_run_id_instr got %h exp %h", id_instr, words[i]); end
      compared++; if (id_pc8 !== RESET_PC + 4 * i + 8 || id_pc4 !== RESET_PC + 4 * i + 4) begin
        mismatched++; $display("FAIL free_run_pc4_pc8 got %h/%h exp %h/%h", id_pc4, id_pc8, RESET_PC + 4 * i + 4, RESET_PC + 4 * i + 8); end
    end
    compared++; if (fetch_cnt !== 3 || id_valid !== 1'b1) begin mismatched++; $display("FAIL free_run_cnt got %0d v=%0b exp 3 v=1", fetch_cnt, id_valid); end
    tick(0, 0, 0, 0);  // advance pc to 0x3010
    compared++; if (pc4 !== 32'h3014) begin mismatched++; $display("FAIL free_run_pc got pc4=%h exp %h", pc4, 32'h3014); end
  endtask

  task automatic test_redirect();
    tick(0, 0, 1, 32'h3100);
    compared++; if (id_pc !== 32'h3010) begin mismatched++; $display("FAIL redirect_delay_slot got %h exp %h", id_pc, 32'h3010); end
    compared++; if (im_addr !== 10'h040 || pc4 !== 32'h3104) begin mismatched++; $display("FAIL redirect_im_addr got %h pc4=%h exp 040 pc4=3104", im_addr, pc4); end
    tick(0, 0, 0, 0);
    compared++; if (id_pc !== 32'h3100 || id_instr !== m_instr) begin
      mismatched++; $display("FAIL redirect_target got pc=%h instr=%h exp %h/%h", id_pc, id_instr, 32'h3100, m_instr); end
  endtask

  task automatic test_stall();
    logic [31:0] pc4_0, idpc_0, cnt_0, instr_0;
    pc4_0 = pc4; idpc_0 = id_pc; cnt_0 = fetch_cnt; instr_0 = id_instr;
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 1, 32'h3200);
      compared++; if (pc4 !== pc4_0 || id_pc !== idpc_0 || id_instr !== instr_0 || fetch_cnt !== cnt_0) begin
        mismatched++; $display("FAIL stall_hold got pc4=%h id_pc=%h cnt=%0d exp %h/%h/%0d", pc4, id_pc, fetch_cnt, pc4_0, idpc_0, cnt_0); end
    end
    tick(0, 0, 1, 32'h3200);
    compared++; if (pc4 !== 32'h3204 || id_pc !== idpc_0 + 4 || fetch_cnt !== cnt_0 + 1) begin
      mismatched++; $display("FAIL stall_release got pc4=%h id_pc=%h cnt=%0d exp 3204/%h/%0d", pc4, id_pc, fetch_cnt, idpc_0 + 4, cnt_0 + 1); end
  endtask

  task automatic test_misaligned();
    tick(0, 0, 1, 32'h3040);
    tick(0, 0, 1, 32'h3102);
    compared++; if (id_pc !== 32'h3040 || id_valid !== 1'b1) begin mismatched++; $display("FAIL misaligned_slot got pc=%h v=%0b exp 3040 v=1", id_pc, id_valid); end
    compared++; if (fetch_err !== 1'b1 || err_addr !== 32'h3102) begin mismatched++; $display("FAIL misaligned_err got err=%0b addr=%h exp 1/3102", fetch_err, err_addr); end
    tick(0, 1, 0, 0);
    compared++; if (id_pc !== 32'h3040 || id_valid !== 1'b1) begin mismatched++; $display("FAIL halt_stall_hold got pc=%h v=%0b exp 3040 v=1", id_pc, id_valid); end
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 1, 32'h3000);
      compared++; if (id_instr !== 0 || id_valid !== 1'b0 || id_pc !== 0 || id_pc8 !== 0) begin
        mismatched++; $display("FAIL halt_bubble got instr=%h v=%0b pc=%h exp 0", id_instr, id_valid, id_pc); end
      compared++; if (pc4 !== 32'h3044 || fetch_err !== 1'b1 || err_addr !== 32'h3102) begin
        mismatched++; $display("FAIL halt_sticky got pc4=%h err=%0b addr=%h exp 3044/1/3102", pc4, fetch_err, err_addr); end
    end
  endtask

  task automatic test_reset_in_halt();
    tick(1, 1, 1, 32'h3100);
    compared++; if (pc4 !== 32'h3004 || fetch_err !== 1'b0 || fetch_cnt !== 0 || id_valid !== 1'b0 || err_addr !== 0) begin
      mismatched++; $display("FAIL reset_in_halt got pc4=%h err=%0b cnt=%0d v=%0b addr=%h exp 3004/0/0/0/0", pc4, fetch_err, fetch_cnt, id_valid, err_addr); end
    tick(0, 0, 0, 0);
    compared++; if (id_pc !== RESET_PC || id_valid !== 1'b1) begin mismatched++; $display("FAIL reset_in_halt_resume got pc=%h v=%0b exp 3000 v=1", id_pc, id_valid); end
  endtask

  task automatic test_end_of_memory();
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 32'h3FF8);
    tick(0, 0, 0, 0);
    compared++; if (id_pc !== 32'h3FF8 || fetch_err !== 1'b0 || im_addr !== 10'h3FF) begin
      mismatched++; $display("FAIL eom_last_word got pc=%h err=%0b im_addr=%h exp 3FF8/0/3FF", id_pc, fetch_err, im_addr); end
    tick(0, 0, 0, 0);
    compared++; if (id_pc !== 32'h3FFC || id_valid !== 1'b1 || id_instr !== imem[DEPTH-1]) begin
      mismatched++; $display("FAIL eom_latched got pc=%h v=%0b instr=%h exp 3FFC/1/%h", id_pc, id_valid, id_instr, imem[DEPTH-1]); end
    compared++; if (fetch_err !== 1'b1 || err_addr !== 32'h4000) begin mismatched++; $display("FAIL eom_err got err=%0b addr=%h exp 1/4000", fetch_err, err_addr); end
  endtask

  task automatic test_low_bound();
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 32'h3000);
    compared++; if (fetch_err !== 1'b0 || pc4 !== 32'h3004) begin mismatched++; $display("FAIL low_bound_legal got err=%0b pc4=%h exp 0/3004", fetch_err, pc4); end
    tick(0, 0, 1, 32'h2FFC);
    compared++; if (fetch_err !== 1'b1 || err_addr !== 32'h2FFC || id_pc !== 32'h3000) begin
      mismatched++; $display("FAIL low_bound_err got err=%0b addr=%h id_pc=%h exp 1/2FFC/3000", fetch_err, err_addr, id_pc); end
  endtask

  task automatic test_random();
    logic [31:0] np;
    bit          r, s, rd;
    logic [31:0] corners [4];
    corners[0] = 32'h2FFC; corners[1] = 32'h3000; corners[2] = 32'h3FFC; corners[3] = 32'h4000;
    for (int i = 0; i < 600; i++) begin
      r  = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 19))
        0:       np = $urandom;
        1:       np = corners[$urandom_range(0, 3)];
        2:       np = RESET_PC + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        default: np = RESET_PC + 4 * $urandom_range(0, DEPTH - 1);
      endcase
      tick(r, s, rd, np);
      compared++;
      if (pc4 !== m_pc + 4 || im_addr !== IM_AW'((m_pc - RESET_PC) >> 2)) begin
        mismatched++; $display("FAIL rand_pc cyc=%0d got pc4=%h im_addr=%h exp %h/%h", i, pc4, im_addr, m_pc + 4, IM_AW'((m_pc - RESET_PC) >> 2)); end
      compared++;
      if (id_instr !== m_instr || id_pc !== m_idpc || id_pc4 !== m_idpc4 || id_pc8 !== m_idpc8 || id_valid !== m_valid) begin
        mismatched++; $display("FAIL rand_ifid cyc=%0d got %h/%h/%h/%h/%0b exp %h/%h/%h/%h/%0b", i,
                               id_instr, id_pc, id_pc4, id_pc8, id_valid, m_instr, m_idpc, m_idpc4, m_idpc8, m_valid); end
      compared++;
      if (fetch_err !== m_err || err_addr !== m_erraddr || fetch_cnt !== m_cnt) begin
        mismatched++; $display("FAIL rand_status cyc=%0d got err=%0b addr=%h cnt=%0d exp %0b/%h/%0d", i,
                               fetch_err, err_addr, fetch_cnt, m_err, m_erraddr, m_cnt); end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; npc = '0;
    m_pc = RESET_PC; m_halt = 0; m_instr = 0; m_idpc = 0; m_idpc4 = 0;
    m_idpc8 = 0; m_valid = 0; m_err = 0; m_erraddr = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
    test_reset();
    test_free_run();
    test_redirect();
    test_stall();
    test_misaligned();
    test_reset_in_halt();
    test_end_of_memory();
    test_low_bound();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
